// File: rtl/jk_sync_down_counter_pkg.sv
// Shared sequential-counter definitions: JK command encodings used by the
// JK-based up and down counters, plus helpers that build per-bit commands.
package jk_sync_down_counter_pkg;

   typedef logic [1:0] jk_cmd_t;

   // {J,K} encodings
   localparam jk_cmd_t JK_HOLD = 2'b00;
   localparam jk_cmd_t JK_RST  = 2'b01;
   localparam jk_cmd_t JK_SET  = 2'b10;
   localparam jk_cmd_t JK_TGL  = 2'b11;

   // Force a bit to a value: J=d, K=~d
   function automatic jk_cmd_t jk_force(input logic d);
      return d ? JK_SET : JK_RST;
   endfunction

   // Toggle when t is set, hold otherwise: J=K=t
   function automatic jk_cmd_t jk_toggle(input logic t);
      return t ? JK_TGL : JK_HOLD;
   endfunction

endpackage

// File: rtl/jk_sync_down_counter_jk_ff_n.sv
// Single JK flip-flop, asynchronous active-low reset to 0.
// {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff_n
   import jk_sync_down_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   // JK state update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            JK_HOLD: q <= q;
            JK_RST:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/jk_sync_down_counter.sv
// Loadable synchronous down counter built from per-bit JK flip-flops.
// Counts to zero, emits a one-cycle borrow, then wraps to all-ones or
// auto-reloads rl_val.
module jk_sync_down_counter
   import jk_sync_down_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             auto_rl,
   input  logic [WIDTH-1:0] rl_val,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             borrow
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] tgl;
   logic [WIDTH-1:0] j_in;
   logic [WIDTH-1:0] k_in;
   logic             term;

   assign q    = cnt;
   assign zero = (cnt == '0);
   // Terminal-count edge: counting from zero without a load overriding it
   assign term = en & ~load & zero;

   // Down-count toggle chain: a bit flips when every lower bit is 0
   always_comb begin
      tgl    = '0;
      tgl[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         tgl[i] = tgl[i-1] & ~cnt[i-1];
      end
   end

   // Per-bit J/K select: load > auto-reload at zero > count > hold
   always_comb begin
      jk_cmd_t cmd;
      j_in = '0;
      k_in = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (load) begin
            cmd = jk_force(din[i]);
         end else if (en && zero && auto_rl) begin
            cmd = jk_force(rl_val[i]);
         end else if (en) begin
            cmd = jk_toggle(tgl[i]);
         end else begin
            cmd = JK_HOLD;
         end
         j_in[i] = cmd[1];
         k_in[i] = cmd[0];
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      jk_ff_n u_ff (
         .clk (clk),
         .rst (rst),
         .j   (j_in[g]),
         .k   (k_in[g]),
         .q   (cnt[g])
      );
   end

   // Borrow pulse lands with the wrapped / reloaded value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         borrow <= 1'b0;
      end else begin
         borrow <= term;
      end
   end

endmodule

// File: tb/tb_jk_sync_down_counter.sv
// Directed bench for jk_sync_down_counter, WIDTH=4.
module tb_jk_sync_down_counter;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] din;
   logic             auto_rl;
   logic [WIDTH-1:0] rl_val;
   logic [WIDTH-1:0] q;
   logic             zero;
   logic             borrow;

   int n_checks = 0;
   int n_errors = 0;

   jk_sync_down_counter #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .din     (din),
      .auto_rl (auto_rl),
      .rl_val  (rl_val),
      .q       (q),
      .zero    (zero),
      .borrow  (borrow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int eq, input int eb);
      chk({tag, " q"}, int'(q), eq);
      chk({tag, " zero"}, int'(zero), (eq == 0) ? 1 : 0);
      chk({tag, " borrow"}, int'(borrow), eb);
   endtask

   int ar_seq [9] = '{1, 0, 5, 4, 3, 2, 1, 0, 5};

   initial begin
      rst = 1'b0; en = 1'b0; load = 1'b0; din = '0; auto_rl = 1'b0; rl_val = '0;
      #3;
      chk_all("reset", 0, 0);
      #9;
      rst = 1'b1;
      chk_all("post_reset", 0, 0);

      // free-running wrap
      en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk_all($sformatf("wrap%0d", k), (16 - k) % 16, (k == 1) ? 1 : 0);
      end

      // load 9 then count through zero
      en = 1'b0; load = 1'b1; din = 4'd9;
      tick();
      chk_all("load9", 9, 0);
      load = 1'b0; en = 1'b1;
      for (int k = 8; k >= 0; k--) begin
         tick();
         chk_all($sformatf("cnt9_%0d", k), k, 0);
      end
      tick();
      chk_all("wrap_after_9", 15, 1);
      tick();
      chk_all("after_wrap", 14, 0);

      // auto-reload
      en = 1'b0; auto_rl = 1'b1; rl_val = 4'd5; load = 1'b1; din = 4'd2;
      tick();
      chk_all("ar_load2", 2, 0);
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk_all($sformatf("ar%0d", k), ar_seq[k], (ar_seq[k] == 5) ? 1 : 0);
      end

      // load beats terminal count
      en = 1'b0; load = 1'b1; din = 4'd0;
      tick();
      chk_all("load0", 0, 0);
      en = 1'b1; din = 4'd7;
      tick();
      chk_all("load_wins", 7, 0);

      // divide-by-1
      en = 1'b0; din = 4'd0;
      tick();
      chk_all("load0b", 0, 0);
      load = 1'b0; en = 1'b1; auto_rl = 1'b1; rl_val = 4'd0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("div1_%0d", k), 0, 1);
      end

      // enable gating
      auto_rl = 1'b0; en = 1'b0; load = 1'b1; din = 4'd6;
      tick();
      chk_all("load6", 6, 0);
      load = 1'b0;
      tick();
      chk_all("hold6a", 6, 0);
      tick();
      chk_all("hold6b", 6, 0);
      en = 1'b1;
      tick();
      chk_all("resume5", 5, 0);
      tick();
      chk_all("resume4", 4, 0);

      // asynchronous reset mid-count
      en = 1'b0; load = 1'b1; din = 4'd11;
      tick();
      chk_all("load11", 11, 0);
      load = 1'b0; en = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 0, 0);
      rst = 1'b1;
      tick();
      chk_all("rst_resume15", 15, 1);
      tick();
      chk_all("rst_resume14", 14, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
